// File: rtl/ex_stage_pkg.sv
// Shared opcode, result-class and divider-state definitions for the execute stage.
package ex_stage_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned EXC_OV_BIT = 12;

    // Operation codes
    localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [7:0] EXE_MOVZ_OP  = 8'b0000_1010;
    localparam logic [7:0] EXE_MOVN_OP  = 8'b0000_1011;
    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
    localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
    localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
    localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
    localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
    localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
    localparam logic [7:0] EXE_ADDI_OP  = 8'b0101_0101;
    localparam logic [7:0] EXE_ADDIU_OP = 8'b0101_0110;
    localparam logic [7:0] EXE_CLZ_OP   = 8'b1011_0000;
    localparam logic [7:0] EXE_CLO_OP   = 8'b1011_0001;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_MUL_OP   = 8'b1010_1001;
    localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
    localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
    localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
    localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    // Result classes
    localparam logic [2:0] EXE_RES_NOP         = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC       = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT       = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE        = 3'b011;
    localparam logic [2:0] EXE_RES_ARITHMETIC  = 3'b100;
    localparam logic [2:0] EXE_RES_MUL         = 3'b101;
    localparam logic [2:0] EXE_RES_JUMP_BRANCH = 3'b110;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    function automatic logic [DATA_W-1:0] neg32(input logic [DATA_W-1:0] x);
        return DATA_W'(~x + DATA_W'(1));
    endfunction

    function automatic logic [DATA_W-1:0] clz32(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] n;
        logic              hit;
        n   = '0;
        hit = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (x[i])
                hit = 1'b1;
            else if (!hit)
                n = n + DATA_W'(1);
        end
        return n;
    endfunction

endpackage

// File: rtl/ex_stage_div.sv
// Radix-2 restoring divider, one quotient bit per cycle, with sign correction on the last step.
module ex_stage_div
    import ex_stage_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                i_start,
    input  logic                i_annul,
    input  logic                i_signed,
    input  logic [DATA_W-1:0]   i_opdata1,
    input  logic [DATA_W-1:0]   i_opdata2,
    output logic [2*DATA_W-1:0] o_result,
    output logic                o_ready
);

    localparam int unsigned CNT_W = $clog2(DIV_CYCLES) + 1;

    div_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0] r_rem, r_quo, r_dsor;
    logic [DATA_W-1:0] w_rem_nxt, w_quo_nxt, w_dsor_nxt;
    logic              r_neg_q, r_neg_r, w_neg_q_nxt, w_neg_r_nxt;
    logic [DATA_W:0]   w_part;
    logic              w_ge;
    logic [DATA_W-1:0] w_step_rem, w_step_quo;

    // Shift-subtract step: partial remainder always fits 32 bits after restore
    always_comb begin : step
        w_part     = {r_rem, r_quo[DATA_W-1]};
        w_ge       = w_part >= {1'b0, r_dsor};
        w_step_rem = w_ge ? DATA_W'(w_part - {1'b0, r_dsor}) : w_part[DATA_W-1:0];
        w_step_quo = {r_quo[DATA_W-2:0], w_ge};
    end

    always_comb begin : fsm_next
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rem_nxt   = r_rem;
        w_quo_nxt   = r_quo;
        w_dsor_nxt  = r_dsor;
        w_neg_q_nxt = r_neg_q;
        w_neg_r_nxt = r_neg_r;
        o_ready     = DivResultNotReady;
        if (i_annul) begin
            w_state_nxt = DivFree;
        end else begin
            case (r_state)
                DivFree: begin
                    if (i_start) begin
                        w_cnt_nxt = '0;
                        w_rem_nxt = '0;
                        if (i_opdata2 == '0) begin
                            w_quo_nxt   = '0;
                            w_state_nxt = DivByZero;
                        end else begin
                            w_quo_nxt   = (i_signed && i_opdata1[DATA_W-1]) ? neg32(i_opdata1) : i_opdata1;
                            w_dsor_nxt  = (i_signed && i_opdata2[DATA_W-1]) ? neg32(i_opdata2) : i_opdata2;
                            w_neg_q_nxt = i_signed && (i_opdata1[DATA_W-1] ^ i_opdata2[DATA_W-1]);
                            w_neg_r_nxt = i_signed && i_opdata1[DATA_W-1];
                            w_state_nxt = DivOn;
                        end
                    end
                end
                // Zero divisor: result registers already hold zero
                DivByZero: begin
                    o_ready     = DivResultReady;
                    w_state_nxt = DivFree;
                end
                DivOn: begin
                    w_rem_nxt = w_step_rem;
                    w_quo_nxt = w_step_quo;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(DIV_CYCLES - 1)) begin
                        w_quo_nxt   = r_neg_q ? neg32(w_step_quo) : w_step_quo;
                        w_rem_nxt   = r_neg_r ? neg32(w_step_rem) : w_step_rem;
                        w_state_nxt = DivEnd;
                    end
                end
                DivEnd: begin
                    o_ready     = DivResultReady;
                    w_state_nxt = DivFree;
                end
                default: w_state_nxt = DivFree;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin : fsm_reg
        if (!resetn) begin
            r_state <= DivFree;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dsor  <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rem   <= w_rem_nxt;
            r_quo   <= w_quo_nxt;
            r_dsor  <= w_dsor_nxt;
            r_neg_q <= w_neg_q_nxt;
            r_neg_r <= w_neg_r_nxt;
        end
    end

    assign o_result = {r_rem, r_quo};

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU results plus multi-cycle divide and multiply-accumulate
// that hold the pipeline via stallreq_o while busy.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic [7:0]        aluop_i,
    input  logic [2:0]        alusel_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] link_address_i,
    input  logic              is_in_delayslot_i,
    input  logic [DATA_W-1:0] excepttype_i,
    input  logic [DATA_W-1:0] current_inst_addr_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              whilo_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              stallreq_o,
    output logic [DATA_W-1:0] excepttype_o,
    output logic [DATA_W-1:0] current_inst_addr_o,
    output logic              is_in_delayslot_o
);

    logic [DATA_W-1:0]   w_sum, w_diff;
    logic                w_ov;
    logic [2*DATA_W-1:0] w_prod_s, w_prod_u, w_madd_prod;
    logic [DATA_W-1:0]   w_logic, w_shift, w_move, w_arith;
    logic                w_is_madd, w_is_div;
    logic                w_div_ready;
    logic [2*DATA_W-1:0] w_div_result;
    logic                r_madd_cnt;
    logic [2*DATA_W-1:0] r_hilo_temp;

    assign w_sum  = reg1_i + reg2_i;
    assign w_diff = reg1_i - reg2_i;

    always_comb begin : overflow
        w_ov = 1'b0;
        if (aluop_i == EXE_ADD_OP || aluop_i == EXE_ADDI_OP)
            w_ov = (reg1_i[DATA_W-1] == reg2_i[DATA_W-1]) && (w_sum[DATA_W-1] != reg1_i[DATA_W-1]);
        else if (aluop_i == EXE_SUB_OP)
            w_ov = (reg1_i[DATA_W-1] != reg2_i[DATA_W-1]) && (w_diff[DATA_W-1] != reg1_i[DATA_W-1]);
    end

    // Sign-extending to 64 bits lets one unsigned multiplier produce the signed product
    assign w_prod_s = {{DATA_W{reg1_i[DATA_W-1]}}, reg1_i} * {{DATA_W{reg2_i[DATA_W-1]}}, reg2_i};
    assign w_prod_u = {{DATA_W{1'b0}}, reg1_i} * {{DATA_W{1'b0}}, reg2_i};

    assign w_is_madd = (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MADDU_OP) ||
                       (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
    assign w_is_div  = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);

    always_comb begin : madd_product
        w_madd_prod = (aluop_i == EXE_MADD_OP || aluop_i == EXE_MSUB_OP) ? w_prod_s : w_prod_u;
        if (aluop_i == EXE_MSUB_OP || aluop_i == EXE_MSUBU_OP)
            w_madd_prod = (2*DATA_W)'(~w_madd_prod + (2*DATA_W)'(1));
    end

    always_comb begin : class_results
        w_logic = '0;
        w_shift = '0;
        w_move  = '0;
        w_arith = '0;
        case (aluop_i)
            EXE_AND_OP:   w_logic = reg1_i & reg2_i;
            EXE_OR_OP:    w_logic = reg1_i | reg2_i;
            EXE_XOR_OP:   w_logic = reg1_i ^ reg2_i;
            EXE_NOR_OP:   w_logic = ~(reg1_i | reg2_i);
            EXE_SLL_OP:   w_shift = reg2_i << reg1_i[4:0];
            EXE_SRL_OP:   w_shift = reg2_i >> reg1_i[4:0];
            EXE_SRA_OP:   w_shift = DATA_W'($signed(reg2_i) >>> reg1_i[4:0]);
            EXE_MOVZ_OP,
            EXE_MOVN_OP:  w_move  = reg1_i;
            EXE_MFHI_OP:  w_move  = hi_i;
            EXE_MFLO_OP:  w_move  = lo_i;
            EXE_ADD_OP, EXE_ADDU_OP,
            EXE_ADDI_OP, EXE_ADDIU_OP: w_arith = w_sum;
            EXE_SUB_OP,
            EXE_SUBU_OP:  w_arith = w_diff;
            EXE_SLT_OP:   w_arith = {{(DATA_W-1){1'b0}}, $signed(reg1_i) < $signed(reg2_i)};
            EXE_SLTU_OP:  w_arith = {{(DATA_W-1){1'b0}}, reg1_i < reg2_i};
            EXE_CLZ_OP:   w_arith = clz32(reg1_i);
            EXE_CLO_OP:   w_arith = clz32(~reg1_i);
            default: ;
        endcase
    end

    ex_stage_div #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .i_start   (w_is_div && !w_div_ready),
        .i_annul   (flush),
        .i_signed  (aluop_i == EXE_DIV_OP),
        .i_opdata1 (reg1_i),
        .i_opdata2 (reg2_i),
        .o_result  (w_div_result),
        .o_ready   (w_div_ready)
    );

    // MADD: first cycle captures the product, second cycle accumulates into HI/LO
    always_ff @(posedge clk or negedge resetn) begin : madd_reg
        if (!resetn) begin
            r_madd_cnt  <= 1'b0;
            r_hilo_temp <= '0;
        end else if (flush || !w_is_madd) begin
            r_madd_cnt  <= 1'b0;
        end else if (!r_madd_cnt) begin
            r_hilo_temp <= w_madd_prod;
            r_madd_cnt  <= 1'b1;
        end else begin
            r_madd_cnt  <= 1'b0;
        end
    end

    always_comb begin : outputs
        wd_o                = wd_i;
        wreg_o              = wreg_i;
        wdata_o             = '0;
        whilo_o             = 1'b0;
        hi_o                = '0;
        lo_o                = '0;
        stallreq_o          = 1'b0;
        excepttype_o        = excepttype_i;
        current_inst_addr_o = current_inst_addr_i;
        is_in_delayslot_o   = is_in_delayslot_i;

        if (w_ov) begin
            excepttype_o[EXC_OV_BIT] = 1'b1;
            wreg_o                   = 1'b0;
        end

        case (alusel_i)
            EXE_RES_LOGIC:       wdata_o = w_logic;
            EXE_RES_SHIFT:       wdata_o = w_shift;
            EXE_RES_MOVE:        wdata_o = w_move;
            EXE_RES_ARITHMETIC:  wdata_o = w_arith;
            EXE_RES_MUL:         wdata_o = w_prod_s[DATA_W-1:0];
            EXE_RES_JUMP_BRANCH: wdata_o = link_address_i;
            default: ;
        endcase

        case (aluop_i)
            EXE_MULT_OP: begin
                whilo_o      = 1'b1;
                {hi_o, lo_o} = w_prod_s;
            end
            EXE_MULTU_OP: begin
                whilo_o      = 1'b1;
                {hi_o, lo_o} = w_prod_u;
            end
            EXE_MTHI_OP: begin
                whilo_o = 1'b1;
                hi_o    = reg1_i;
                lo_o    = lo_i;
            end
            EXE_MTLO_OP: begin
                whilo_o = 1'b1;
                hi_o    = hi_i;
                lo_o    = reg1_i;
            end
            EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP: begin
                if (!r_madd_cnt) begin
                    stallreq_o = 1'b1;
                end else if (!flush) begin
                    whilo_o      = 1'b1;
                    {hi_o, lo_o} = r_hilo_temp + {hi_i, lo_i};
                end
            end
            EXE_DIV_OP, EXE_DIVU_OP: begin
                stallreq_o = !w_div_ready;
                if (w_div_ready && !flush) begin
                    whilo_o      = 1'b1;
                    {hi_o, lo_o} = w_div_result;
                end
            end
            default: ;
        endcase

        if (!resetn) begin
            wd_o                = '0;
            wreg_o              = 1'b0;
            wdata_o             = '0;
            whilo_o             = 1'b0;
            hi_o                = '0;
            lo_o                = '0;
            stallreq_o          = 1'b0;
            excepttype_o        = '0;
            current_inst_addr_o = '0;
            is_in_delayslot_o   = 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: vector table for single-cycle ops, hand sequences for DIV/MADD/flush/reset.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] link_address_i;
    logic        is_in_delayslot_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic [31:0] hi_i, lo_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o, lo_o;
    logic        stallreq_o;
    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic        is_in_delayslot_o;

    int n_checks = 0;
    int n_fail   = 0;

    ex_stage dut (
        .clk                 (clk),
        .resetn              (resetn),
        .flush               (flush),
        .aluop_i             (aluop_i),
        .alusel_i            (alusel_i),
        .reg1_i              (reg1_i),
        .reg2_i              (reg2_i),
        .wd_i                (wd_i),
        .wreg_i              (wreg_i),
        .link_address_i      (link_address_i),
        .is_in_delayslot_i   (is_in_delayslot_i),
        .excepttype_i        (excepttype_i),
        .current_inst_addr_i (current_inst_addr_i),
        .hi_i                (hi_i),
        .lo_i                (lo_i),
        .wd_o                (wd_o),
        .wreg_o              (wreg_o),
        .wdata_o             (wdata_o),
        .whilo_o             (whilo_o),
        .hi_o                (hi_o),
        .lo_o                (lo_o),
        .stallreq_o          (stallreq_o),
        .excepttype_o        (excepttype_o),
        .current_inst_addr_o (current_inst_addr_o),
        .is_in_delayslot_o   (is_in_delayslot_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] r1, r2, hi, lo;
        logic [31:0] e_wdata;
        logic        e_wreg;
        logic        e_whilo;
        logic [31:0] e_hi, e_lo;
        logic        e_ov;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [7:0] op, input logic [2:0] sel,
                           input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] hi, input logic [31:0] lo,
                           input logic [31:0] e_wdata, input logic e_wreg, input logic e_whilo,
                           input logic [31:0] e_hi, input logic [31:0] e_lo, input logic e_ov);
        vec_t v;
        v.name = name; v.op = op; v.sel = sel; v.r1 = r1; v.r2 = r2; v.hi = hi; v.lo = lo;
        v.e_wdata = e_wdata; v.e_wreg = e_wreg; v.e_whilo = e_whilo;
        v.e_hi = e_hi; v.e_lo = e_lo; v.e_ov = e_ov;
        vecs.push_back(v);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, " wd_o"},       64'(wd_o), 64'd0);
        chk({name, " wreg_o"},     64'(wreg_o), 64'd0);
        chk({name, " wdata_o"},    64'(wdata_o), 64'd0);
        chk({name, " whilo_o"},    64'(whilo_o), 64'd0);
        chk({name, " hi_lo"},      {hi_o, lo_o}, 64'd0);
        chk({name, " stallreq_o"}, 64'(stallreq_o), 64'd0);
        chk({name, " excepttype"}, 64'(excepttype_o), 64'd0);
        chk({name, " pc_ds"},      {31'd0, is_in_delayslot_o, current_inst_addr_o}, 64'd0);
    endtask

    // Issues a DIV/DIVU and counts stall cycles up to the writeback cycle
    task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int exp_stall,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        int early_whilo;
        @(posedge clk); #1;
        aluop_i = op; alusel_i = EXE_RES_NOP; reg1_i = a; reg2_i = b;
        #1;
        n = 0;
        early_whilo = 0;
        while (stallreq_o === 1'b1 && n < 100) begin
            if (whilo_o !== 1'b0) early_whilo++;
            @(posedge clk); #2;
            n++;
        end
        chk({name, " stall_cycles"}, 64'(n), 64'(exp_stall));
        chk({name, " whilo_during_stall"}, 64'(early_whilo), 64'd0);
        chk({name, " whilo_o"}, 64'(whilo_o), 64'd1);
        chk({name, " hi_lo"}, {hi_o, lo_o}, {exp_hi, exp_lo});
    endtask

    task automatic run_madd(input string name, input logic [7:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        @(posedge clk); #1;
        aluop_i = op; alusel_i = EXE_RES_NOP; reg1_i = a; reg2_i = b; hi_i = hi; lo_i = lo;
        #1;
        chk({name, " c1 stall"}, 64'(stallreq_o), 64'd1);
        chk({name, " c1 whilo"}, 64'(whilo_o), 64'd0);
        @(posedge clk); #2;
        chk({name, " c2 stall"}, 64'(stallreq_o), 64'd0);
        chk({name, " c2 whilo"}, 64'(whilo_o), 64'd1);
        chk({name, " c2 hi_lo"}, {hi_o, lo_o}, {exp_hi, exp_lo});
        @(posedge clk); #1;
        aluop_i = EXE_NOP_OP;
    endtask

    initial begin
        int seen;
        resetn = 1'b0; flush = 1'b0;
        aluop_i = EXE_ADD_OP; alusel_i = EXE_RES_ARITHMETIC;
        reg1_i = 32'h7FFF_FFFF; reg2_i = 32'h0000_0001;
        wd_i = 5'd7; wreg_i = 1'b1; link_address_i = 32'h0040_0008;
        is_in_delayslot_i = 1'b1; excepttype_i = 32'h0000_0200;
        current_inst_addr_i = 32'hBFC0_0100; hi_i = '0; lo_i = '0;

        repeat (2) @(posedge clk);
        #2;
        check_all_zero("reset");
        @(negedge clk);
        resetn = 1'b1;
        aluop_i = EXE_NOP_OP; alusel_i = EXE_RES_NOP;

        // name, op, sel, r1, r2, hi_i, lo_i, wdata, wreg, whilo, hi, lo, ov
        add_vec("and",   EXE_AND_OP,   EXE_RES_LOGIC, 32'hF0F0_FFFF, 32'h0FF0_F00F, 0, 0, 32'h00F0_F00F, 1, 0, 0, 0, 0);
        add_vec("or",    EXE_OR_OP,    EXE_RES_LOGIC, 32'h1234_0000, 32'h0000_5678, 0, 0, 32'h1234_5678, 1, 0, 0, 0, 0);
        add_vec("xor",   EXE_XOR_OP,   EXE_RES_LOGIC, 32'hFFFF_0000, 32'h0F0F_0F0F, 0, 0, 32'hF0F0_0F0F, 1, 0, 0, 0, 0);
        add_vec("nor",   EXE_NOR_OP,   EXE_RES_LOGIC, 32'h0000_FFFF, 32'h00FF_0000, 0, 0, 32'hFF00_0000, 1, 0, 0, 0, 0);
        add_vec("sll",   EXE_SLL_OP,   EXE_RES_SHIFT, 32'd4,  32'h0000_0003, 0, 0, 32'h0000_0030, 1, 0, 0, 0, 0);
        add_vec("sra",   EXE_SRA_OP,   EXE_RES_SHIFT, 32'd4,  32'h8000_0000, 0, 0, 32'hF800_0000, 1, 0, 0, 0, 0);
        add_vec("srl",   EXE_SRL_OP,   EXE_RES_SHIFT, 32'd31, 32'h8000_0000, 0, 0, 32'h0000_0001, 1, 0, 0, 0, 0);
        add_vec("add_ov",  EXE_ADD_OP,  EXE_RES_ARITHMETIC, 32'h7FFF_FFFF, 32'd1, 0, 0, 32'h8000_0000, 0, 0, 0, 0, 1);
        add_vec("addi_ov", EXE_ADDI_OP, EXE_RES_ARITHMETIC, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h7FFF_FFFF, 0, 0, 0, 0, 1);
        add_vec("addu",  EXE_ADDU_OP,  EXE_RES_ARITHMETIC, 32'h7FFF_FFFF, 32'd1, 0, 0, 32'h8000_0000, 1, 0, 0, 0, 0);
        add_vec("sub_ov",  EXE_SUB_OP,  EXE_RES_ARITHMETIC, 32'h8000_0000, 32'd1, 0, 0, 32'h7FFF_FFFF, 0, 0, 0, 0, 1);
        add_vec("sub",   EXE_SUB_OP,   EXE_RES_ARITHMETIC, 32'd5, 32'd7, 0, 0, 32'hFFFF_FFFE, 1, 0, 0, 0, 0);
        add_vec("slt",   EXE_SLT_OP,   EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'd1, 0, 0, 32'd1, 1, 0, 0, 0, 0);
        add_vec("sltu",  EXE_SLTU_OP,  EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'd1, 0, 0, 32'd0, 1, 0, 0, 0, 0);
        add_vec("clz",   EXE_CLZ_OP,   EXE_RES_ARITHMETIC, 32'h0001_0000, 32'd0, 0, 0, 32'd15, 1, 0, 0, 0, 0);
        add_vec("clo",   EXE_CLO_OP,   EXE_RES_ARITHMETIC, 32'hF000_0000, 32'd0, 0, 0, 32'd4, 1, 0, 0, 0, 0);
        add_vec("mult",  EXE_MULT_OP,  EXE_RES_NOP, 32'hFFFF_FFFE, 32'd3, 0, 0, 32'd0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);
        add_vec("multu", EXE_MULTU_OP, EXE_RES_NOP, 32'hFFFF_FFFF, 32'd2, 0, 0, 32'd0, 1, 1, 32'h0000_0001, 32'hFFFF_FFFE, 0);
        add_vec("mul",   EXE_MUL_OP,   EXE_RES_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'd1, 1, 0, 0, 0, 0);
        add_vec("mfhi",  EXE_MFHI_OP,  EXE_RES_MOVE, 32'd0, 32'd0, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1, 0, 0, 0, 0);
        add_vec("mtlo",  EXE_MTLO_OP,  EXE_RES_NOP, 32'h1111_2222, 32'd0, 32'hAAAA_0000, 32'h5555_5555, 32'd0, 1, 1, 32'hAAAA_0000, 32'h1111_2222, 0);
        add_vec("jal",   EXE_NOP_OP,   EXE_RES_JUMP_BRANCH, 32'd0, 32'd0, 0, 0, 32'h0040_0008, 1, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            aluop_i = vecs[i].op; alusel_i = vecs[i].sel;
            reg1_i = vecs[i].r1; reg2_i = vecs[i].r2; hi_i = vecs[i].hi; lo_i = vecs[i].lo;
            #1;
            chk({vecs[i].name, " wdata"}, 64'(wdata_o), 64'(vecs[i].e_wdata));
            chk({vecs[i].name, " wreg"},  64'(wreg_o), 64'(vecs[i].e_wreg));
            chk({vecs[i].name, " whilo"}, 64'(whilo_o), 64'(vecs[i].e_whilo));
            chk({vecs[i].name, " hi_lo"}, {hi_o, lo_o}, {vecs[i].e_hi, vecs[i].e_lo});
            chk({vecs[i].name, " excepttype"}, 64'(excepttype_o),
                64'(vecs[i].e_ov ? 32'h0000_1200 : 32'h0000_0200));
            chk({vecs[i].name, " stall"}, 64'(stallreq_o), 64'd0);
        end
        chk("passthrough", {wd_o, is_in_delayslot_o, current_inst_addr_o}, {26'd0, 5'd7, 1'b1, 32'hBFC0_0100});
        hi_i = '0; lo_i = '0;

        // Multiply-accumulate family
        run_madd("madd",  EXE_MADD_OP,  32'd3, 32'd5, 32'd0, 32'd10, 32'd0, 32'd25);
        run_madd("msub",  EXE_MSUB_OP,  32'd2, 32'd3, 32'd0, 32'd10, 32'd0, 32'd4);
        run_madd("maddu", EXE_MADDU_OP, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd1, 32'd1, 32'hFFFF_FFFF);

        // Back-to-back divides, then divide by zero
        run_div("div_neg7_2",  EXE_DIV_OP,  32'hFFFF_FFF9, 32'd2,  33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_div("divu_b2b",    EXE_DIVU_OP, 32'hFFFF_FFFF, 32'h10, 33, 32'h0000_000F, 32'h0FFF_FFFF);
        run_div("divu_by_zero", EXE_DIVU_OP, 32'd100, 32'd0, 1, 32'd0, 32'd0);
        @(posedge clk); #1;
        aluop_i = EXE_NOP_OP;
        #1;
        chk("after_div whilo", 64'(whilo_o), 64'd0);

        // Flush on the fifth cycle of a divide
        @(posedge clk); #1;
        aluop_i = EXE_DIVU_OP; reg1_i = 32'd100; reg2_i = 32'd7;
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        chk("flush whilo", 64'(whilo_o), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; aluop_i = EXE_NOP_OP;
        #1;
        chk("flush next stall", 64'(stallreq_o), 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #2;
            if (whilo_o !== 1'b0) seen++;
        end
        chk("flush no writeback", 64'(seen), 64'd0);
        run_div("divu_after_flush", EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'd2, 32'd14);

        // Reset on the tenth DivOn cycle
        @(posedge clk); #1;
        aluop_i = EXE_DIV_OP; reg1_i = 32'd100; reg2_i = 32'hFFFF_FFFD;
        repeat (10) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check_all_zero("reset_mid_div");
        @(posedge clk); #1;
        aluop_i = EXE_NOP_OP;
        @(negedge clk);
        resetn = 1'b1;
        run_div("div_after_reset", EXE_DIV_OP, 32'd100, 32'hFFFF_FFFD, 33, 32'd1, 32'hFFFF_FFDF);
        @(posedge clk); #1;
        aluop_i = EXE_NOP_OP;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
